// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and helpers for the sequential multiplier
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold values 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add multiplier with valid/ready handshakes and signed mode
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t          r_state;
    logic [PW-1:0]   r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_neg;
    logic [PW-1:0]   r_product;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [PW-1:0]    w_acc_next;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign w_mag_a    = (in_signed && in_a[WIDTH-1]) ? (-in_a) : in_a;
    assign w_mag_b    = (in_signed && in_b[WIDTH-1]) ? (-in_b) : in_b;
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Handshake outputs depend only on the state register.
    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign out_product = r_product;

    // FSM and shift-add datapath: one partial-product bit per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_mcand  <= r_mcand << 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_product <= r_neg ? (-w_acc_next) : w_acc_next;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FORMAL
    localparam logic [PW-1:0] ACC_MAX = {{WIDTH{1'b0}}, {WIDTH{1'b1}}} * {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] f_ma;
    logic [WIDTH-1:0] f_mb;
    logic             f_neg;
    logic [PW-1:0]    f_prod;
    logic [WIDTH-1:0] f_mask;

    // Shadow copy of the accepted operand magnitudes.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_ma  <= '0;
            f_mb  <= '0;
            f_neg <= 1'b0;
        end else if (in_valid && in_ready) begin
            f_ma  <= w_mag_a;
            f_mb  <= w_mag_b;
            f_neg <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        end
    end

    assign f_prod = PW'(f_ma) * PW'(f_mb);
    assign f_mask = (WIDTH'(1) << r_cnt) - WIDTH'(1);

    // Immediate checks of result, partial-product invariant and bound.
    always_comb begin
        if (!rst && r_state == DONE) begin
            assert (out_product == (f_neg ? (-f_prod) : f_prod));
        end
        if (!rst && r_state == CALC) begin
            assert (r_acc == PW'(f_ma) * PW'(f_mb & f_mask));
        end
        assert (r_acc <= ACC_MAX);
    end

    a_monotonic: assert property (@(posedge clk) disable iff (rst)
        (r_state == CALC) |=> (r_state != CALC || r_acc >= $past(r_acc)));

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_product)));
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_product;

    logic        w_in_valid, w_in_ready, w_in_signed, w_out_valid, w_out_ready, w_busy;
    logic [15:0] w_in_a, w_in_b;
    logic [31:0] w_out_product;

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .busy(busy)
    );

    seq_multiplier #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_signed(w_in_signed),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_product(w_out_product), .busy(w_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] p, output int lat);
        int g;
        g = 0;
        while (!in_ready && g < 50) begin step(); g++; end
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_signed = ~s;
        lat = 0;
        while (!out_valid && lat < 100) begin step(); lat++; end
        p = out_product;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [31:0] p, output int lat);
        int g;
        g = 0;
        while (!w_in_ready && g < 50) begin step(); g++; end
        w_in_a = a; w_in_b = b; w_in_signed = s; w_in_valid = 1'b1;
        step();
        w_in_valid = 1'b0;
        w_in_a = ~a; w_in_b = ~b; w_in_signed = ~s;
        lat = 0;
        while (!w_out_valid && lat < 100) begin step(); lat++; end
        p = w_out_product;
        w_out_ready = 1'b1;
        step();
        w_out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        logic [31:0] p32;
        int          lat;
        logic        bad;
        logic        acc_now;
        logic [7:0]  pa[3];
        logic [7:0]  pb[3];
        logic [15:0] pexp[3];
        logic [15:0] res[3];
        int          tstamp[3];
        int          idx, nres, cyc;

        vecs[0] = '{8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255"};
        vecs[1] = '{8'h80,  8'h80,  1'b1, 16'h4000, "s-128x-128"};
        vecs[2] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, "s-3x5"};
        vecs[3] = '{8'hFD,  8'd5,   1'b0, 16'd1265, "u253x5"};
        vecs[4] = '{8'h80,  8'h01,  1'b1, 16'hFF80, "s-128x1"};
        vecs[5] = '{8'h7F,  8'hFF,  1'b1, 16'hFF81, "s127x-1"};
        vecs[6] = '{8'd0,   8'd200, 1'b0, 16'h0000, "u0x200"};
        vecs[7] = '{8'h80,  8'h7F,  1'b1, 16'hC080, "s-128x127"};

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_signed = 1'b0; w_out_ready = 1'b0;
        step();
        step();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_product", out_product, 0);
        check("reset16_product", w_out_product, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
            check({vecs[i].name, "_product"}, p, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, 8);
        end
        check("post_pop_in_ready", in_ready, 1);
        check("post_pop_keeps_product", out_product, 16'hC080);

        // Backpressure: result held for 20 cycles, then popped.
        in_a = 8'd12; in_b = 8'd13; in_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin step(); lat++; end
        check("bp_latency", lat, 8);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!(out_valid === 1'b1 && out_product === 16'd156 && in_ready === 1'b0 && busy === 1'b1))
                bad = 1'b1;
            if (i < 19) step();
        end
        check("bp_stable_20_cycles", bad, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_in_ready_after_pop", in_ready, 1);
        check("bp_out_valid_after_pop", out_valid, 0);
        check("bp_product_kept", out_product, 16'd156);

        // Reset in the 4th CALC cycle discards the operation.
        in_a = 8'd200; in_b = 8'd100; in_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("rst_busy_before", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_product", out_product, 0);
        run8(8'd7, 8'd9, 1'b0, p, lat);
        check("after_rst_7x9", p, 16'd63);
        check("after_rst_latency", lat, 8);

        // Back-to-back with both sides always ready.
        pa[0] = 8'd3; pa[1] = 8'd0; pa[2] = 8'd1;
        pb[0] = 8'd4; pb[1] = 8'd0; pb[2] = 8'd255;
        pexp[0] = 16'd12; pexp[1] = 16'd0; pexp[2] = 16'd255;
        for (int i = 0; i < 3; i++) begin res[i] = 16'hDEAD; tstamp[i] = 0; end
        idx = 0; nres = 0; cyc = 0;
        out_ready = 1'b1;
        in_a = pa[0]; in_b = pb[0]; in_signed = 1'b0; in_valid = 1'b1;
        while (nres < 3 && cyc < 200) begin
            acc_now = in_valid && in_ready;
            step();
            cyc++;
            if (acc_now) begin
                idx++;
                if (idx < 3) begin in_a = pa[idx]; in_b = pb[idx]; end
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                res[nres] = out_product;
                tstamp[nres] = cyc;
                nres++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", nres, 3);
        for (int i = 0; i < 3; i++) check($sformatf("b2b_result%0d", i), res[i], pexp[i]);
        check("b2b_spacing01", tstamp[1] - tstamp[0], 10);
        check("b2b_spacing12", tstamp[2] - tstamp[1], 10);

        // WIDTH=16 instance.
        run16(16'hFFFF, 16'hFFFF, 1'b0, p32, lat);
        check("w16_u_max_product", p32, 32'hFFFE0001);
        check("w16_u_max_latency", lat, 16);
        run16(16'h8000, 16'h0001, 1'b1, p32, lat);
        check("w16_s_min_x1", p32, 32'hFFFF8000);
        check("w16_s_min_latency", lat, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
